// File: rtl/lsu_pkg.sv
// rtl/lsu_pkg.sv - shared load/store funct3 encodings, FSM state type and helpers
package lsu_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  typedef enum logic {IDLE, REQ} lsu_state_t;

  function automatic int timeout_cnt_width(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles + 1);
  endfunction

  function automatic logic funct3_legal(input logic is_load, input logic [2:0] f3);
    if (is_load) return f3 inside {F3_LB, F3_LH, F3_LW, F3_LBU, F3_LHU};
    return f3 inside {F3_SB, F3_SH, F3_SW};
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// rtl/lsu_lane_align.sv - byte-lane steering for stores and extraction/extension for loads
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [2:0]  st_funct3_i,
  input  logic [1:0]  st_offset_i,
  input  logic [31:0] st_wdata_i,
  output logic [3:0]  be_o,
  output logic [31:0] lane_wdata_o,
  input  logic [2:0]  ld_funct3_i,
  input  logic [1:0]  ld_offset_i,
  input  logic [31:0] ld_rdata_i,
  output logic [31:0] ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  // funct3[1:0] is the access size for both loads and stores
  always_comb begin
    be_o         = 4'b0000;
    lane_wdata_o = st_wdata_i;
    case (st_funct3_i[1:0])
      2'b00: begin
        be_o         = 4'b0001 << st_offset_i;
        lane_wdata_o = {4{st_wdata_i[7:0]}};
      end
      2'b01: begin
        be_o         = st_offset_i[1] ? 4'b1100 : 4'b0011;
        lane_wdata_o = {2{st_wdata_i[15:0]}};
      end
      2'b10:   be_o = 4'b1111;
      default: be_o = 4'b0000;
    endcase
  end

  assign ld_byte = ld_rdata_i[{ld_offset_i, 3'b000} +: 8];
  assign ld_half = ld_rdata_i[{ld_offset_i[1], 4'b0000} +: 16];

  always_comb begin
    ld_data_o = '0;
    case (ld_funct3_i)
      F3_LB:   ld_data_o = {{24{ld_byte[7]}}, ld_byte};
      F3_LH:   ld_data_o = {{16{ld_half[15]}}, ld_half};
      F3_LW:   ld_data_o = ld_rdata_i;
      F3_LBU:  ld_data_o = {24'b0, ld_byte};
      F3_LHU:  ld_data_o = {16'b0, ld_half};
      default: ld_data_o = '0;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - MEM-stage load/store responder driving a word-aligned data bus
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  ex_valid,
  input  logic                  ex_mem_read,
  input  logic                  ex_mem_write,
  input  logic [2:0]            ex_funct3,
  input  logic [ADDR_WIDTH-1:0] ex_addr,
  input  logic [DATA_WIDTH-1:0] ex_wdata,
  input  logic [4:0]            ex_rd,
  output logic                  lsu_busy,
  output logic                  wb_valid,
  output logic [4:0]            wb_rd,
  output logic [DATA_WIDTH-1:0] wb_rdata,
  output logic                  misalign_fault,
  output logic                  access_fault,
  output logic [ADDR_WIDTH-1:0] fault_addr,
  output logic                  dmem_req,
  output logic                  dmem_we,
  output logic [ADDR_WIDTH-1:0] dmem_addr,
  output logic [3:0]            dmem_be,
  output logic [DATA_WIDTH-1:0] dmem_wdata,
  input  logic                  dmem_ack,
  input  logic [DATA_WIDTH-1:0] dmem_rdata
);

  localparam int             CW      = timeout_cnt_width(TIMEOUT_CYCLES);
  localparam logic [CW-1:0]  TO_LAST = CW'(TIMEOUT_CYCLES - 1);

  lsu_state_t            state_q;
  logic [ADDR_WIDTH-1:0] addr_q;
  logic [2:0]            funct3_q;
  logic [4:0]            rd_q;
  logic [CW-1:0]         cnt_q;
  logic                  dmem_req_q, dmem_we_q;
  logic [ADDR_WIDTH-1:0] dmem_addr_q;
  logic [3:0]            dmem_be_q;
  logic [DATA_WIDTH-1:0] dmem_wdata_q;
  logic                  wb_valid_q;
  logic [4:0]            wb_rd_q;
  logic [DATA_WIDTH-1:0] wb_rdata_q;
  logic                  misalign_q, access_q;
  logic [ADDR_WIDTH-1:0] fault_addr_q;

  logic                  accept, legal, aligned;
  logic [3:0]            st_be;
  logic [31:0]           st_wdata, ld_data;

  lsu_lane_align u_align (
    .st_funct3_i  (ex_funct3),
    .st_offset_i  (ex_addr[1:0]),
    .st_wdata_i   (ex_wdata),
    .be_o         (st_be),
    .lane_wdata_o (st_wdata),
    .ld_funct3_i  (funct3_q),
    .ld_offset_i  (addr_q[1:0]),
    .ld_rdata_i   (dmem_rdata),
    .ld_data_o    (ld_data)
  );

  // Legality is judged first; alignment only matters for a legal size
  always_comb begin
    accept  = ex_valid & (ex_mem_read | ex_mem_write);
    legal   = ~(ex_mem_read & ex_mem_write) & funct3_legal(ex_mem_read, ex_funct3);
    aligned = 1'b1;
    case (ex_funct3[1:0])
      2'b01:   aligned = ~ex_addr[0];
      2'b10:   aligned = (ex_addr[1:0] == 2'b00);
      default: aligned = 1'b1;
    endcase
  end

  assign lsu_busy = ((state_q == IDLE) && accept && legal && aligned) ||
                    ((state_q == REQ) && !dmem_ack);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      addr_q       <= '0;
      funct3_q     <= '0;
      rd_q         <= '0;
      cnt_q        <= '0;
      dmem_req_q   <= 1'b0;
      dmem_we_q    <= 1'b0;
      dmem_addr_q  <= '0;
      dmem_be_q    <= '0;
      dmem_wdata_q <= '0;
      wb_valid_q   <= 1'b0;
      wb_rd_q      <= '0;
      wb_rdata_q   <= '0;
      misalign_q   <= 1'b0;
      access_q     <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      wb_valid_q <= 1'b0;
      misalign_q <= 1'b0;
      access_q   <= 1'b0;
      case (state_q)
        IDLE: begin
          if (accept) begin
            if (!legal) begin
              access_q     <= 1'b1;
              fault_addr_q <= ex_addr;
            end else if (!aligned) begin
              misalign_q   <= 1'b1;
              fault_addr_q <= ex_addr;
            end else begin
              state_q      <= REQ;
              addr_q       <= ex_addr;
              funct3_q     <= ex_funct3;
              rd_q         <= ex_rd;
              cnt_q        <= '0;
              dmem_req_q   <= 1'b1;
              dmem_we_q    <= ex_mem_write;
              dmem_addr_q  <= {ex_addr[ADDR_WIDTH-1:2], 2'b00};
              dmem_be_q    <= st_be;
              dmem_wdata_q <= st_wdata;
            end
          end
        end
        REQ: begin
          if (dmem_ack) begin
            state_q    <= IDLE;
            dmem_req_q <= 1'b0;
            if (!dmem_we_q) begin
              wb_valid_q <= 1'b1;
              wb_rd_q    <= rd_q;
              wb_rdata_q <= ld_data;
            end
          end else if (cnt_q == TO_LAST) begin
            state_q      <= IDLE;
            dmem_req_q   <= 1'b0;
            access_q     <= 1'b1;
            fault_addr_q <= addr_q;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign dmem_req       = dmem_req_q;
  assign dmem_we        = dmem_we_q;
  assign dmem_addr      = dmem_addr_q;
  assign dmem_be        = dmem_be_q;
  assign dmem_wdata     = dmem_wdata_q;
  assign wb_valid       = wb_valid_q;
  assign wb_rd          = wb_rd_q;
  assign wb_rdata       = wb_rdata_q;
  assign misalign_fault = misalign_q;
  assign access_fault   = access_q;
  assign fault_addr     = fault_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - scoreboard bench for load_store_unit with a byte-memory reference model
module tb_load_store_unit;
  import lsu_pkg::*;

  localparam int TO = 255;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ex_valid, ex_mem_read, ex_mem_write;
  logic [2:0]  ex_funct3;
  logic [31:0] ex_addr, ex_wdata;
  logic [4:0]  ex_rd;
  logic        lsu_busy, wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_rdata;
  logic        misalign_fault, access_fault;
  logic [31:0] fault_addr;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr;
  logic [3:0]  dmem_be;
  logic [31:0] dmem_wdata;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst_n(rst_n),
    .ex_valid(ex_valid), .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
    .ex_funct3(ex_funct3), .ex_addr(ex_addr), .ex_wdata(ex_wdata), .ex_rd(ex_rd),
    .lsu_busy(lsu_busy), .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_rdata(wb_rdata),
    .misalign_fault(misalign_fault), .access_fault(access_fault), .fault_addr(fault_addr),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [3:0]  be;
    logic [31:0] wdata;
    bit          chk_wdata;
  } bus_exp_t;
  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
  } wb_exp_t;
  typedef struct {
    int          kind;
    logic [31:0] addr;
  } fault_exp_t;

  bus_exp_t   bus_q[$];
  wb_exp_t    wb_q[$];
  fault_exp_t fault_q[$];

  byte unsigned mem[int unsigned];

  function automatic byte unsigned mem_byte(input int unsigned a);
    if (!mem.exists(a)) mem[a] = 8'($urandom);
    return mem[a];
  endfunction

  function automatic int size_of(input logic [2:0] f3);
    case (f3)
      3'd0, 3'd4: return 1;
      3'd1, 3'd5: return 2;
      3'd2:       return 4;
      default:    return 0;
    endcase
  endfunction

  function automatic bit ref_legal(input bit rop, input bit wop, input logic [2:0] f3);
    if (rop && wop) return 1'b0;
    if (rop) return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2 || f3 == 3'd4 || f3 == 3'd5);
    return (f3 == 3'd0 || f3 == 3'd1 || f3 == 3'd2);
  endfunction

  function automatic logic [31:0] ref_word(input logic [31:0] a);
    logic [31:0] w;
    for (int i = 0; i < 4; i++) w[8*i +: 8] = mem_byte(int'(a) + i);
    return w;
  endfunction

  function automatic logic [31:0] ref_load(input logic [2:0] f3, input logic [31:0] a);
    int n;
    logic [31:0] v;
    n = size_of(f3);
    v = 0;
    for (int i = 0; i < n; i++) v = v + (32'(mem_byte(int'(a) + i)) << (8*i));
    if (n < 4 && f3 != 3'd4 && f3 != 3'd5 && v >= (32'd1 << (8*n - 1)))
      v = v - (32'd1 << (8*n));
    return v;
  endfunction

  task automatic ref_store(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
    for (int i = 0; i < size_of(f3); i++) mem[int'(a) + i] = 8'(d >> (8*i));
  endtask

  // One pipeline op; ack_delay < 0 withholds ack so the access times out
  task automatic do_op(input bit rop, input bit wop, input logic [2:0] f3,
                       input logic [31:0] a, input logic [31:0] d, input logic [4:0] rd,
                       input int ack_delay, output int busy_cnt);
    bit go, legal, aligned;
    int n, exp_busy;
    bus_exp_t be_exp;
    wb_exp_t  wexp;
    busy_cnt = 0;
    n        = size_of(f3);
    legal    = ref_legal(rop, wop, f3);
    aligned  = legal ? ((int'(a[3:0]) % n) == 0) : 1'b0;
    go       = (rop || wop) && legal && aligned;
    exp_busy = !go ? 0 : (ack_delay < 0) ? 1 + TO : 1 + ack_delay;
    @(posedge clk); #1;
    ex_valid = 1'b1; ex_mem_read = rop; ex_mem_write = wop;
    ex_funct3 = f3; ex_addr = a; ex_wdata = d; ex_rd = rd;
    if (rop || wop) begin
      if (!legal) fault_q.push_back('{2, a});
      else if (!aligned) fault_q.push_back('{1, a});
      else begin
        be_exp.we        = wop;
        be_exp.addr      = a & ~32'h3;
        be_exp.be        = 4'(((1 << n) - 1) << (a % 4));
        be_exp.wdata     = (n == 1) ? 32'(d[7:0]) * 32'h01010101 :
                           (n == 2) ? 32'(d[15:0]) * 32'h00010001 : d;
        be_exp.chk_wdata = wop;
        bus_q.push_back(be_exp);
        if (ack_delay < 0) fault_q.push_back('{2, a});
      end
    end
    #1; if (lsu_busy) busy_cnt++;
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    if (go) begin
      if (ack_delay < 0) begin
        for (int c = 0; c < TO + 50; c++) begin
          if (!dmem_req) break;
          #1; if (lsu_busy) busy_cnt++;
          @(posedge clk); #1;
        end
      end else begin
        for (int c = 0; c <= ack_delay; c++) begin
          if (c == ack_delay) begin
            dmem_ack = 1'b1;
            if (rop) begin
              dmem_rdata = ref_word(a & ~32'h3);
              wexp.rd    = rd;
              wexp.data  = ref_load(f3, a);
              wb_q.push_back(wexp);
            end else begin
              dmem_rdata = $urandom;
              ref_store(f3, a, d);
            end
          end
          #1; if (lsu_busy) busy_cnt++;
          @(posedge clk); #1;
          dmem_ack = 1'b0;
        end
      end
    end
    chk("busy_cycles", busy_cnt, exp_busy);
  endtask

  bit          req_seen = 1'b0;
  logic [31:0] held_addr, held_wdata;
  logic [4:0]  held_ctl;

  always @(negedge clk) begin
    bus_exp_t   b;
    wb_exp_t    w;
    fault_exp_t f;
    if (dmem_req) begin
      if (!req_seen) begin
        req_seen = 1'b1;
        if (bus_q.size() == 0) chk("unexpected_dmem_req", dmem_req, 1'b0);
        else begin
          b = bus_q.pop_front();
          chk("dmem_we", dmem_we, b.we);
          chk("dmem_addr", dmem_addr, b.addr);
          chk("dmem_be", dmem_be, b.be);
          if (b.chk_wdata) chk("dmem_wdata", dmem_wdata, b.wdata);
        end
        held_addr  = dmem_addr;
        held_wdata = dmem_wdata;
        held_ctl   = {dmem_we, dmem_be};
      end else begin
        chk("req_stable_addr", dmem_addr, held_addr);
        chk("req_stable_wdata", dmem_wdata, held_wdata);
        chk("req_stable_ctl", 32'({dmem_we, dmem_be}), 32'(held_ctl));
      end
    end else begin
      req_seen = 1'b0;
    end
    if (wb_valid) begin
      if (wb_q.size() == 0) chk("unexpected_wb_valid", wb_valid, 1'b0);
      else begin
        w = wb_q.pop_front();
        chk("wb_rd", 32'(wb_rd), 32'(w.rd));
        chk("wb_rdata", wb_rdata, w.data);
      end
    end
    if (misalign_fault || access_fault) begin
      if (fault_q.size() == 0) chk("unexpected_fault", 32'({misalign_fault, access_fault}), 32'd0);
      else begin
        f = fault_q.pop_front();
        chk("fault_kind", 32'({access_fault, misalign_fault}), (f.kind == 1) ? 32'd1 : 32'd2);
        chk("fault_addr", fault_addr, f.addr);
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int busy;
    int r;
    bit rop, wop;
    logic [2:0] f3;
    logic [2:0] ld_set [5];
    ld_set = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};

    rst_n = 1'b0;
    ex_valid = 1'b0; ex_mem_read = 1'b0; ex_mem_write = 1'b0;
    ex_funct3 = '0; ex_addr = '0; ex_wdata = '0; ex_rd = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_dmem_req", dmem_req, 1'b0);
    chk("reset_lsu_busy", lsu_busy, 1'b0);
    chk("reset_wb_valid", wb_valid, 1'b0);
    chk("reset_wb_rdata", wb_rdata, 32'h0);
    chk("reset_faults", 32'({misalign_fault, access_fault}), 32'd0);
    chk("reset_fault_addr", fault_addr, 32'h0);
    chk("reset_dmem_be", 32'(dmem_be), 32'h0);
    rst_n = 1'b1;

    do_op(1'b0, 1'b1, F3_SW, 32'h100, 32'hDEADBEEF, 5'd0, 1, busy);
    chk("sw_busy_two_cycles", busy, 2);
    chk("sw_no_wb_valid", wb_valid, 1'b0);
    do_op(1'b0, 1'b1, F3_SB, 32'h203, 32'h000000A5, 5'd0, 0, busy);

    mem[32'h300] = 8'h00; mem[32'h301] = 8'h80; mem[32'h302] = 8'h34; mem[32'h303] = 8'h12;
    do_op(1'b1, 1'b0, F3_LB, 32'h301, 32'h0, 5'd5, 0, busy);
    chk("lb_wb_valid_at_T2", wb_valid, 1'b1);
    chk("lb_rdata", wb_rdata, 32'hFFFFFF80);
    do_op(1'b1, 1'b0, F3_LBU, 32'h301, 32'h0, 5'd6, 0, busy);
    chk("lbu_rdata", wb_rdata, 32'h00000080);
    do_op(1'b1, 1'b0, F3_LH, 32'h302, 32'h0, 5'd7, 0, busy);
    chk("lh_rdata", wb_rdata, 32'h00001234);
    @(posedge clk); #1;
    chk("wb_valid_pulse_ends", wb_valid, 1'b0);
    chk("wb_rdata_holds", wb_rdata, 32'h00001234);

    do_op(1'b1, 1'b0, F3_LW, 32'h102, 32'h0, 5'd1, 0, busy);
    chk("misalign_pulse", misalign_fault, 1'b1);
    chk("misalign_addr", fault_addr, 32'h102);
    @(posedge clk); #1;
    chk("misalign_pulse_ends", misalign_fault, 1'b0);
    chk("fault_addr_holds", fault_addr, 32'h102);

    do_op(1'b1, 1'b0, 3'b011, 32'h400, 32'h0, 5'd2, 0, busy);
    chk("illegal_f3_access_fault", access_fault, 1'b1);
    do_op(1'b1, 1'b1, F3_LW, 32'h404, 32'h0, 5'd2, 0, busy);
    chk("rw_both_access_fault", access_fault, 1'b1);

    do_op(1'b1, 1'b0, F3_LW, 32'h500, 32'h0, 5'd3, -1, busy);
    chk("timeout_access_fault", access_fault, 1'b1);
    chk("timeout_fault_addr", fault_addr, 32'h500);
    chk("timeout_req_dropped", dmem_req, 1'b0);

    @(posedge clk); #1;
    ex_valid = 1'b1; ex_mem_read = 1'b1; ex_funct3 = F3_LW; ex_addr = 32'h40; ex_rd = 5'd7;
    bus_q.push_back('{1'b0, 32'h40, 4'hF, 32'h0, 1'b0});
    @(posedge clk); #1;
    ex_valid = 1'b0; ex_mem_read = 1'b0;
    repeat (3) @(posedge clk);
    #3;
    chk("pre_reset_req_pending", dmem_req, 1'b1);
    rst_n = 1'b0;
    #1;
    chk("async_reset_req", dmem_req, 1'b0);
    chk("async_reset_busy", lsu_busy, 1'b0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    do_op(1'b1, 1'b0, F3_LW, 32'h44, 32'h0, 5'd9, 2, busy);
    chk("post_reset_lw_wb_valid", wb_valid, 1'b1);

    for (int i = 0; i < 200; i++) begin
      r   = $urandom_range(0, 9);
      rop = (r == 0) || (r >= 2 && r <= 5);
      wop = (r == 0) || (r >= 6);
      if ($urandom_range(0, 3) == 0) f3 = 3'($urandom);
      else if (rop) f3 = ld_set[$urandom_range(0, 4)];
      else f3 = 3'($urandom_range(0, 2));
      do_op(rop, wop, f3, 32'h1000 + $urandom_range(0, 31), $urandom, 5'($urandom),
            $urandom_range(0, 3), busy);
    end

    repeat (3) @(posedge clk);
    #1;
    chk("bus_queue_drained", bus_q.size(), 0);
    chk("wb_queue_drained", wb_q.size(), 0);
    chk("fault_queue_drained", fault_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
